cp0_vec: RTL and testbench

CP0_VEC -- requirements
Module: cp0_vec

---
 rtl/cp0_vec_if.sv | 18 +
 rtl/cp0_vec.sv | 168 ++++++++++++++++
 tb/tb_cp0_vec.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_vec_if.sv
// cp0_vec_if: mtc0/mfc0 register access bus of the CP0 block.
// The master drives the address/write side, the slave returns rdata.
interface cp0_vec_if;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_we;
  logic [31:0] cp0_rdata;

  modport master (
    output cp0_addr, cp0_wdata, cp0_we,
    input  cp0_rdata
  );

  modport slave (
    input  cp0_addr, cp0_wdata, cp0_we,
    output cp0_rdata
  );
endinterface

// File: rtl/cp0_vec.sv
// cp0_vec: CP0 status/cause/EPC/EBase with vectored interrupts.
// Define CP0_VEC_TIMER_EN to build the Count/Compare timer.
module cp0_vec #(
  parameter int          NUM_INT     = 6,
  parameter logic [31:0] EBASE_RST   = 32'h0000_4180,
  parameter logic [31:0] VEC_SPACING = 32'h20
) (
  input  logic               clk,
  input  logic               reset,
  cp0_vec_if.slave           bus,
  input  logic [31:0]        vpc,
  input  logic               bd_in,
  input  logic [4:0]         exc_code_in,
  input  logic [NUM_INT-1:0] hw_int,
  input  logic               eret,
  output logic               req,
  output logic [31:0]        epc_out,
  output logic [31:0]        vector_out,
  output logic               exl_out
);

  logic               ie, exl;
  logic [NUM_INT-1:0] im;
  logic               bd;
  logic [NUM_INT-1:0] ip;
  logic [4:0]         exc_code;
  logic [31:0]        epc, ebase;
  logic [31:0]        count, compare;
  logic               ti;

  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        we;
  assign addr  = bus.cp0_addr;
  assign wdata = bus.cp0_wdata;
  assign we    = bus.cp0_we;

  logic sel_cnt, sel_cmp, sel_sr;
  logic sel_cause, sel_epc, sel_ebase;
  assign sel_cnt   = (addr == 5'd9);
  assign sel_cmp   = (addr == 5'd11);
  assign sel_sr    = (addr == 5'd12);
  assign sel_cause = (addr == 5'd13);
  assign sel_epc   = (addr == 5'd14);
  assign sel_ebase = (addr == 5'd15);

  logic we_eff;
  assign we_eff = we & ~req;

  logic [NUM_INT-1:0] ti_vec, ip_live, pend;
  always_comb begin
    ti_vec = '0;
    ti_vec[NUM_INT-1] = ti;
  end
  assign ip_live = hw_int | ti_vec;
  assign pend    = ip_live & im;

  logic int_req, exc_req;
  assign int_req = (|pend) & ie & ~exl;
  assign exc_req = (exc_code_in != 5'd0) & ~exl;
  assign req     = reset & (int_req | exc_req);

  // Ascending scan: the last hit is the highest pending line.
  logic [2:0] idx;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_INT; i++)
      if (pend[i]) idx = 3'(i);
  end

  logic [31:0] int_vec;
  assign int_vec = ebase
    + VEC_SPACING * (32'(idx) + 32'd1);

  assign vector_out = exc_req ? ebase : int_vec;
  assign epc_out = !req ? epc
                 : bd_in ? vpc - 32'd4 : vpc;
  assign exl_out = exl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
      ebase    <= EBASE_RST;
    end else begin
      ip <= ip_live;
      if (req) begin
        exl      <= 1'b1;
        epc      <= epc_out;
        bd       <= bd_in;
        exc_code <= exc_req ? exc_code_in : 5'd0;
      end else begin
        if (we && sel_sr) begin
          ie  <= wdata[0];
          exl <= wdata[1];
          im  <= wdata[10 +: NUM_INT];
        end
        // eret lands after any same-cycle SR write.
        if (eret) exl <= 1'b0;
        if (we && sel_epc)
          epc <= {wdata[31:2], 2'b00};
        if (we && sel_ebase)
          ebase <= {wdata[31:2], 2'b00};
      end
    end
  end

`ifdef CP0_VEC_TIMER_EN
  logic [31:0] count_nxt;
  assign count_nxt = (we_eff && sel_cnt)
                   ? wdata : count + 32'd1;

  // TI is set on the edge Count reaches Compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_nxt;
      if (we_eff && sel_cmp) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count_nxt == compare) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  logic [31:0] sr_r, cause_r, rdata;
  always_comb begin
    sr_r = '0;
    sr_r[0] = ie;
    sr_r[1] = exl;
    sr_r[10 +: NUM_INT] = im;
    cause_r = '0;
    cause_r[31] = bd;
    cause_r[30] = ti;
    cause_r[10 +: NUM_INT] = ip;
    cause_r[6:2] = exc_code;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_cnt:   rdata = count;
      sel_cmp:   rdata = compare;
      sel_sr:    rdata = sr_r;
      sel_cause: rdata = cause_r;
      sel_epc:   rdata = epc;
      sel_ebase: rdata = ebase;
      default:   rdata = '0;
    endcase
  end

  assign bus.cp0_rdata = rdata;

endmodule

// File: tb/tb_cp0_vec.sv
// tb_cp0_vec: directed vector table plus sequences for cp0_vec.
// Timer checks are built when CP0_VEC_TIMER_EN is defined.
module tb_cp0_vec;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] vector_out;
  logic        exl_out;

  int checks   = 0;
  int failures = 0;

  cp0_vec_if bus_if ();

  cp0_vec dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .eret        (eret),
    .req         (req),
    .epc_out     (epc_out),
    .vector_out  (vector_out),
    .exl_out     (exl_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sr;
    logic [5:0]  hw;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] vpc;
    logic        exp_req;
    logic [31:0] exp_vec;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    bus_if.cp0_addr  = a;
    bus_if.cp0_wdata = d;
    bus_if.cp0_we    = 1'b1;
    tick;
    bus_if.cp0_we    = 1'b0;
  endtask

  task automatic rd(input string nm,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    bus_if.cp0_addr = a;
    #1;
    chk(nm, bus_if.cp0_rdata, exp);
  endtask

  task automatic idle;
    hw_int      = '0;
    exc_code_in = '0;
    bd_in       = 1'b0;
    eret        = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h401,  6'b000001, 5'd0,  1'b0,
                32'h3000, 1'b1, 32'h41A0, 32'h3000};
    vecs[1] = '{32'h1401, 6'b000101, 5'd0,  1'b0,
                32'h3000, 1'b1, 32'h41E0, 32'h3000};
    vecs[2] = '{32'h1400, 6'b000101, 5'd0,  1'b0,
                32'h3000, 1'b0, 32'h0,    32'h0};
    vecs[3] = '{32'hFC01, 6'b100000, 5'd0,  1'b0,
                32'h3000, 1'b1, 32'h4240, 32'h3000};
    vecs[4] = '{32'hFC01, 6'b111111, 5'd0,  1'b1,
                32'h3000, 1'b1, 32'h4240, 32'h2FFC};
    vecs[5] = '{32'h401,  6'b000010, 5'd0,  1'b0,
                32'h3000, 1'b0, 32'h0,    32'h0};
    vecs[6] = '{32'h401,  6'b000001, 5'd10, 1'b1,
                32'h3008, 1'b1, 32'h4180, 32'h3004};
    vecs[7] = '{32'h403,  6'b000001, 5'd3,  1'b0,
                32'h3000, 1'b0, 32'h0,    32'h0};
    vecs[8] = '{32'h0,    6'b000000, 5'd4,  1'b0,
                32'h5000, 1'b1, 32'h4180, 32'h5000};
    vecs[9] = '{32'h0,    6'b000000, 5'd1,  1'b1,
                32'h2,    1'b1, 32'h4180, 32'hFFFF_FFFE};

    reset = 1'b0;
    vpc = '0;
    idle;
    bus_if.cp0_addr  = '0;
    bus_if.cp0_wdata = '0;
    bus_if.cp0_we    = 1'b0;

    #12;
    exc_code_in = 5'd9;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    exc_code_in = 5'd0;
    rd("rst_sr",    5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc",   5'd14, 32'h0);
    rd("rst_ebase", 5'd15, 32'h4180);
    #4;
    reset = 1'b1;
`ifdef CP0_VEC_TIMER_EN
    wr(5'd11, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 10; i++) begin
      wr(5'd12, vecs[i].sr);
      hw_int      = vecs[i].hw;
      exc_code_in = vecs[i].exc;
      bd_in       = vecs[i].bd;
      vpc         = vecs[i].vpc;
      #1;
      chk($sformatf("v%0d_req", i),
          32'(req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        chk($sformatf("v%0d_vec", i),
            vector_out, vecs[i].exp_vec);
      chk($sformatf("v%0d_epc", i),
          epc_out, vecs[i].exp_epc);
      idle;
      #1;
    end

    wr(5'd12, 32'h401);
    hw_int = 6'b000001;
    vpc = 32'h3000;
    #1;
    chk("int_req", 32'(req), 32'd1);
    tick;
    chk("int_exl", 32'(exl_out), 32'd1);
    chk("int_mask", 32'(req), 32'd0);
    rd("int_epc", 5'd14, 32'h3000);
    rd("int_cause", 5'd13, 32'h0000_0400);

    hw_int = '0;
    exc_code_in = 5'd4;
    eret = 1'b1;
    #1;
    chk("eret_req", 32'(req), 32'd0);
    tick;
    idle;
    chk("eret_exl", 32'(exl_out), 32'd0);

    exc_code_in = 5'd10;
    hw_int = 6'b000001;
    bd_in = 1'b1;
    vpc = 32'h3008;
    bus_if.cp0_addr  = 5'd14;
    bus_if.cp0_wdata = 32'hDEAD_BEEC;
    bus_if.cp0_we    = 1'b1;
    #1;
    chk("exc_vec", vector_out, 32'h4180);
    chk("exc_epco", epc_out, 32'h3004);
    tick;
    bus_if.cp0_we = 1'b0;
    exc_code_in = 5'd0;
    bd_in = 1'b0;
    rd("exc_epc", 5'd14, 32'h3004);
    rd("exc_cause", 5'd13, 32'h8000_0428);
    chk("exc_exl", 32'(exl_out), 32'd1);

    hw_int = '0;
    eret = 1'b1;
    tick;
    chk("eret2_exl", 32'(exl_out), 32'd0);
    exc_code_in = 5'd5;
    vpc = 32'h3100;
    #1;
    chk("reqeret_req", 32'(req), 32'd1);
    tick;
    idle;
    chk("reqeret_exl", 32'(exl_out), 32'd1);
    rd("reqeret_cause", 5'd13, 32'h14);

    bus_if.cp0_addr  = 5'd12;
    bus_if.cp0_wdata = 32'h403;
    bus_if.cp0_we    = 1'b1;
    eret = 1'b1;
    tick;
    bus_if.cp0_we = 1'b0;
    eret = 1'b0;
    chk("wreret_exl", 32'(exl_out), 32'd0);
    rd("wreret_sr", 5'd12, 32'h401);
    wr(5'd12, 32'hFFFF_FFFC);
    rd("sr_mask", 5'd12, 32'h0000_FC00);

    wr(5'd14, 32'h1234_5677);
    rd("epc_align", 5'd14, 32'h1234_5674);
    wr(5'd15, 32'hFFFF_FFF3);
    rd("ebase_align", 5'd15, 32'hFFFF_FFF0);
    wr(5'd12, 32'h401);
    hw_int = 6'b000001;
    #1;
    chk("wrap_req", 32'(req), 32'd1);
    chk("wrap_vec", vector_out, 32'h10);
    hw_int = '0;
    #1;
    wr(5'd20, 32'hFFFF_FFFF);
    rd("bad_addr", 5'd20, 32'h0);
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h14);
`ifndef CP0_VEC_TIMER_EN
    wr(5'd9, 32'd5);
    rd("no_count", 5'd9, 32'h0);
    wr(5'd11, 32'd5);
    rd("no_compare", 5'd11, 32'h0);
`endif

    hw_int = 6'b000001;
    vpc = 32'h3000;
    tick;
    hw_int = '0;
    chk("mid_exl", 32'(exl_out), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_exl", 32'(exl_out), 32'd0);
    exc_code_in = 5'd7;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    exc_code_in = 5'd0;
    rd("arst_sr",    5'd12, 32'h0);
    rd("arst_epc",   5'd14, 32'h0);
    rd("arst_ebase", 5'd15, 32'h4180);
    rd("arst_cause", 5'd13, 32'h0);
    @(negedge clk);
    reset = 1'b1;

`ifdef CP0_VEC_TIMER_EN
    begin
      logic hit;
      logic [31:0] c;
      hit = 1'b0;
      wr(5'd11, 32'd5);
      wr(5'd12, 32'h8001);
      for (int i = 0; i < 20 && !hit; i++) begin
        #1;
        if (req) hit = 1'b1;
        else tick;
      end
      chk("ti_req", 32'(req), 32'd1);
      rd("ti_count", 5'd9, 32'd5);
      chk("ti_vec", vector_out, 32'h4240);
      bus_if.cp0_addr = 5'd13;
      #1;
      c = bus_if.cp0_rdata;
      chk("ti_set", 32'(c[30]), 32'd1);
      tick;
      bus_if.cp0_addr = 5'd13;
      #1;
      c = bus_if.cp0_rdata;
      chk("ti_hold", 32'(c[30]), 32'd1);
      wr(5'd11, 32'd100);
      bus_if.cp0_addr = 5'd13;
      #1;
      c = bus_if.cp0_rdata;
      chk("ti_clr", 32'(c[30]), 32'd0);
      wr(5'd9, 32'hFFFF_FFFF);
      rd("cnt_load", 5'd9, 32'hFFFF_FFFF);
      tick;
      rd("cnt_wrap", 5'd9, 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
